ps2_key_tracker: RTL
====================

Name: ps2_key_tracker

Overview:
- Consumes raw scan-code bytes from the ps2_keyboard receive FIFO and generates one read-acknowledge pulse per byte.
- Decodes make, break (F0) and extended (E0) sequences, and tracks the currently held key.
- Counts distinct key presses; typematic repeats are excluded. Keeps a shift history of the last HIST_DEPTH pressed codes.
- Sits between ps2_keyboard and the scan-code-to-ASCII / seven-segment display logic in top-level designs.

Parameters:
- COUNT_W, 8, width of key_count; wraps modulo 2^COUNT_W.
- HIST_DEPTH, 4, number of pressed-key codes retained in hist (min 1).
- COUNT_SAT, 0, 1 = key_count saturates at all-ones; 0 = wraps to 0.

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- ps2_byte  in  8  FIFO head byte from ps2_keyboard.
- ps2_ready  in  1  FIFO non-empty.
- ps2_nextdata_n  out  1  active-low read strobe to FIFO, one clk wide.
- key_code  out  8  code of held or last-released key.
- key_ext  out  1  key_code came from an E0 sequence.
- key_valid  out  1  a key is currently held.
- press_pulse  out  1  1-cycle pulse, new key press.
- repeat_pulse  out  1  1-cycle pulse, typematic repeat of held key.
- release_pulse  out  1  1-cycle pulse, held key released.
- key_count  out  COUNT_W  number of presses.
- hist  out  8*HIST_DEPTH  pressed-code history; [7:0] = newest.

Behaviour:
- Reset (clrn=0, asynchronous): all outputs 0 except ps2_nextdata_n=1. Handshake FSM goes to H_IDLE; parse FSM goes to P_NORM.
- Handshake FSM: H_IDLE -> H_ACK -> H_GAP -> H_IDLE.
  - H_IDLE: when ps2_ready=1, latch ps2_byte, go to H_ACK.
  - H_ACK: ps2_nextdata_n=0 for exactly one cycle; the latched byte is processed by the parse FSM in this cycle.
  - H_GAP: ps2_ready ignored for one cycle while the FIFO pointer settles.
  - Maximum throughput: one byte per 3 clk.
- Parse FSM states: P_NORM, P_EXT (E0 seen), P_BRK (F0 seen), P_EXTBRK (E0 F0 seen).
  - E0 in P_NORM -> P_EXT.
  - F0 in P_NORM -> P_BRK; F0 in P_EXT -> P_EXTBRK.
  - 0xAA or 0xFA in any state: byte ignored, FSM -> P_NORM, no pulses.
  - E0 in any state other than P_NORM -> P_EXT (restart the sequence).
  - F0 in P_BRK or P_EXTBRK: stay in the current state.
- Make code C (any other byte, in P_NORM or P_EXT; ext = 1 if in P_EXT):
  - key_valid=1 and {C, ext} equals the held {key_code, key_ext}: repeat_pulse=1; count and hist unchanged.
  - Otherwise: key_code=C, key_ext=ext, key_valid=1, press_pulse=1. key_count increments (saturates at all-ones if COUNT_SAT=1). hist shifts left by 8 with C inserted at [7:0]; the oldest entry is discarded.
  - Rollover: pressing a new key while another is held counts as a new press, and the new key becomes the held key.
  - FSM -> P_NORM.
- Break code C (in P_BRK or P_EXTBRK; ext = 1 if in P_EXTBRK):
  - Matches the held key with key_valid=1: key_valid=0, release_pulse=1; key_code and key_ext are retained.
  - Mismatch: ignored, no pulse.
  - FSM -> P_NORM.
- All pulses are registered and assert in the cycle after H_ACK; at most one pulse per byte.
- clrn asserted mid-sequence (e.g. after E0): the partial sequence is discarded and the next byte is parsed from P_NORM.

Test Plan:
- Reset, then feed 1C, F0 1C -> press_pulse once, key_code=0x1C, key_valid=1; then release_pulse, key_valid=0, key_count=1, hist[7:0]=0x1C. ps2_nextdata_n low for exactly 3 single-cycle strobes.
- Feed 1C 1C 1C F0 1C -> 1 press_pulse, 2 repeat_pulse, 1 release_pulse; key_count=1.
- Feed E0 75, E0 F0 75 -> key_code=0x75, key_ext=1, press then release. Then feed F0 75 (non-extended) while nothing is held -> no pulse.
- Feed 1C, 32, F0 1C, F0 32 -> 2 presses, key_code=0x32. F0 1C gives no pulse; F0 32 releases. With HIST_DEPTH=4, hist=0x00001C32.
- COUNT_W=2, COUNT_SAT=0: 5 distinct presses -> key_count=1. COUNT_SAT=1: key_count=3.
- Feed E0, assert clrn=0 for 2 cycles, then feed 75 -> press with key_ext=0, key_count=1.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: pops scan-code bytes from the ps2_keyboard FIFO, decodes
// make / break / extended sequences, tracks the held key, counts distinct
// presses and keeps a short history of pressed codes.
module ps2_key_tracker #(
  parameter int COUNT_W    = 8,
  parameter int HIST_DEPTH = 4,
  parameter bit COUNT_SAT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [7:0]              ps2_byte,
  input  logic                    ps2_ready,
  output logic                    ps2_nextdata_n,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_valid,
  output logic                    press_pulse,
  output logic                    repeat_pulse,
  output logic                    release_pulse,
  output logic [COUNT_W-1:0]      key_count,
  output logic [8*HIST_DEPTH-1:0] hist
);

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;
  localparam logic [7:0] BYTE_BAT = 8'hAA;
  localparam logic [7:0] BYTE_ACK = 8'hFA;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ACK,
    H_GAP
  } hState_e;

  typedef enum logic [1:0] {
    P_NORM,
    P_EXT,
    P_BRK,
    P_EXTBRK
  } pState_e;

  hState_e hState_q, hState_d;
  pState_e pState_q, pState_d;

  logic [7:0]              byte_q, byte_d;
  logic [7:0]              keyCode_q, keyCode_d;
  logic                    keyExt_q, keyExt_d;
  logic                    keyValid_q, keyValid_d;
  logic                    pressPulse_q, pressPulse_d;
  logic                    repeatPulse_q, repeatPulse_d;
  logic                    releasePulse_q, releasePulse_d;
  logic [COUNT_W-1:0]      keyCount_q, keyCount_d;
  logic [8*HIST_DEPTH-1:0] hist_q, hist_d;

  logic               byteExt;
  logic               isBreak;
  logic               heldMatch;
  logic [COUNT_W-1:0] countNext;

  // The prefix state tells whether the current code is extended and/or a break.
  assign byteExt   = (pState_q == P_EXT) || (pState_q == P_EXTBRK);
  assign isBreak   = (pState_q == P_BRK) || (pState_q == P_EXTBRK);
  assign heldMatch = keyValid_q && (keyCode_q == byte_q) && (keyExt_q == byteExt);
  assign countNext = (COUNT_SAT && (&keyCount_q)) ? keyCount_q : keyCount_q + COUNT_W'(1);

  // The read strobe is low only during the acknowledge cycle.
  assign ps2_nextdata_n = (hState_q != H_ACK);

  assign key_code      = keyCode_q;
  assign key_ext       = keyExt_q;
  assign key_valid     = keyValid_q;
  assign press_pulse   = pressPulse_q;
  assign repeat_pulse  = repeatPulse_q;
  assign release_pulse = releasePulse_q;
  assign key_count     = keyCount_q;
  assign hist          = hist_q;

  // Handshake: latch the FIFO head, strobe it out, then wait a cycle for the FIFO to settle.
  always_comb begin
    hState_d = hState_q;
    byte_d   = byte_q;
    case (hState_q)
      H_IDLE: begin
        if (ps2_ready) begin
          byte_d   = ps2_byte;
          hState_d = H_ACK;
        end
      end
      H_ACK:   hState_d = H_GAP;
      H_GAP:   hState_d = H_IDLE;
      default: hState_d = H_IDLE;
    endcase
  end

  // Parser: consumes the latched byte during the acknowledge cycle and updates the key state.
  always_comb begin
    pState_d       = pState_q;
    keyCode_d      = keyCode_q;
    keyExt_d       = keyExt_q;
    keyValid_d     = keyValid_q;
    keyCount_d     = keyCount_q;
    hist_d         = hist_q;
    pressPulse_d   = 1'b0;
    repeatPulse_d  = 1'b0;
    releasePulse_d = 1'b0;
    if (hState_q == H_ACK) begin
      if ((byte_q == BYTE_BAT) || (byte_q == BYTE_ACK)) begin
        pState_d = P_NORM;
      end else if (byte_q == BYTE_EXT) begin
        pState_d = P_EXT;
      end else if (byte_q == BYTE_BRK) begin
        if (pState_q == P_NORM) begin
          pState_d = P_BRK;
        end else if (pState_q == P_EXT) begin
          pState_d = P_EXTBRK;
        end
      end else begin
        pState_d = P_NORM;
        if (isBreak) begin
          if (heldMatch) begin
            keyValid_d     = 1'b0;
            releasePulse_d = 1'b1;
          end
        end else if (heldMatch) begin
          repeatPulse_d = 1'b1;
        end else begin
          keyCode_d    = byte_q;
          keyExt_d     = byteExt;
          keyValid_d   = 1'b1;
          pressPulse_d = 1'b1;
          keyCount_d   = countNext;
          hist_d       = hist_q << 8;
          hist_d[7:0]  = byte_q;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously by clrn.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hState_q       <= H_IDLE;
      pState_q       <= P_NORM;
      byte_q         <= '0;
      keyCode_q      <= '0;
      keyExt_q       <= 1'b0;
      keyValid_q     <= 1'b0;
      pressPulse_q   <= 1'b0;
      repeatPulse_q  <= 1'b0;
      releasePulse_q <= 1'b0;
      keyCount_q     <= '0;
      hist_q         <= '0;
    end else begin
      hState_q       <= hState_d;
      pState_q       <= pState_d;
      byte_q         <= byte_d;
      keyCode_q      <= keyCode_d;
      keyExt_q       <= keyExt_d;
      keyValid_q     <= keyValid_d;
      pressPulse_q   <= pressPulse_d;
      repeatPulse_q  <= repeatPulse_d;
      releasePulse_q <= releasePulse_d;
      keyCount_q     <= keyCount_d;
      hist_q         <= hist_d;
    end
  end

endmodule
